full_sub_bist: RTL
==================

// Module: full_sub_bist
// PURPOSE
//   Synthesizable self-test engine for the 1-bit full subtractor. Drives all 8 input
//   combinations {a,b,b_in} into the subtractor and checks the returned differ/borrow
//   against a golden model. Reports pass/fail, error count and first failing vector.
//   Sits beside the subtractor instance in lab top-levels; it replaces the manual stimulus bench.
// PARAMETERS
//   SETTLE_CYCLES  1  cycles each vector is held before its response is sampled (legal: >=1)
// PORTS
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   start      in   1  begin a test run; sampled in IDLE or DONE only
//   differ     in   1  difference bit returned by the subtractor under test
//   borrow     in   1  borrow-out bit returned by the subtractor under test
//   a          out  1  minuend bit driven to the subtractor (registered)
//   b          out  1  subtrahend bit driven to the subtractor (registered)
//   b_in       out  1  borrow-in bit driven to the subtractor (registered)
//   busy       out  1  high while a run is in progress (SETTLE/CHECK)
//   done       out  1  high in DONE; held until the next accepted start or reset
//   pass       out  1  done && err_count==0
//   err_count  out  4  number of mismatching vectors this run (0..8)
//   fail_vec   out  3  index {a,b,b_in} of first mismatch; valid when err_count!=0
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; a,b,b_in,busy,done,pass=0; err_count=0; fail_vec=0.
//   - Vector index idx[2:0] runs 0..7; {a,b,b_in}=idx while busy, all 0 in IDLE.
//   - Golden: exp_d = a^b^b_in; exp_b = (~a&b)|(~a&b_in)|(b&b_in).
//   - FSM: IDLE -start-> SETTLE (idx=0, settle_cnt=0, err_count=0, fail_vec=0, done=0).
//     SETTLE: settle_cnt++; when settle_cnt==SETTLE_CYCLES-1 -> CHECK.
//     CHECK: mismatch if differ!=exp_d or borrow!=exp_b; on mismatch err_count++,
//       and if err_count was 0, fail_vec=idx. If idx==7 -> DONE, else idx++, settle_cnt=0, SETTLE.
//     DONE: done=1; start -> SETTLE (new run, counters cleared); otherwise stay.
//   - start is ignored while busy; no restart, no queuing.
//   - Latency: done rises 8*(SETTLE_CYCLES+1) cycles after the edge that accepts start
//     (16 cycles at default). Responses sampled in CHECK, i.e. SETTLE_CYCLES+1 edges after
//     the vector is launched.
//   - err_count cannot exceed 8; 4 bits, no wrap possible.
//   - Inputs differ/borrow are assumed synchronous to clk (combinational DUT in same domain).
// CONFIGURATION
//   FULL_SUB_BIST_STOP_ON_FAIL_EN defined: first mismatch in CHECK goes directly to DONE;
//     err_count=1, fail_vec=idx of that vector, pass=0; remaining vectors not applied.
//   Not defined: all 8 vectors always applied; err_count is total mismatches.
// STRUCTURE
//   Package full_sub_pkg: state encoding (IDLE, SETTLE, CHECK, DONE), NUM_VEC=8,
//     VEC_W=3, and function full_sub_expected(a,b,b_in) returning {exp_d,exp_b}.
//   One sub-module: full_sub_ref_model (combinational golden differ/borrow from a,b,b_in),
//     shareable with benches. FSM, counters and result registers live in full_sub_bist.
// TESTING
//   1 correct subtractor, default params, start pulse -> done at cycle 16, pass=1,
//     err_count=0, a/b/b_in sequence 000..111.
//   2 borrow stuck-at-0 DUT -> err_count=4 (vectors 1,2,3,7), fail_vec=1, pass=0.
//   3 start re-pulsed during busy at cycle 5 -> ignored; done still at cycle 16, results unchanged.
//   4 rst asserted mid-run at idx=3 -> same cycle a,b,b_in,busy=0, err_count=0; new start
//     completes normally with pass=1.
//   5 FULL_SUB_BIST_STOP_ON_FAIL_EN, differ inverted DUT -> done at cycle 2, err_count=1,
//     fail_vec=0; without macro same DUT -> err_count=8, fail_vec=0, done at cycle 16.
//   6 SETTLE_CYCLES=3, correct DUT -> done at cycle 32, pass=1; start in DONE reruns
//     with done deasserted the next cycle.

Source files
------------

// File: rtl/full_sub_pkg.sv
// Shared definitions for the full-subtractor self-test engine: state encoding,
// vector sizing and the golden subtractor function.
package full_sub_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned VEC_W   = 3;
  localparam int unsigned ERR_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Golden 1-bit full subtractor: returns {difference, borrow_out}.
  function automatic logic [1:0] full_sub_expected(input logic a, input logic b,
                                                   input logic b_in);
    logic exp_d;
    logic exp_b;
    exp_d = a ^ b ^ b_in;
    exp_b = (~a & b) | (~a & b_in) | (b & b_in);
    return {exp_d, exp_b};
  endfunction

endpackage

// File: rtl/full_sub_ref_model.sv
// Combinational golden model of a 1-bit full subtractor.
// Ports:
//   a, b, b_in  in   minuend, subtrahend, borrow-in
//   exp_d       out  expected difference bit
//   exp_b       out  expected borrow-out bit
module full_sub_ref_model
  import full_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic exp_d,
  output logic exp_b
);

  always_comb begin
    {exp_d, exp_b} = full_sub_expected(a, b, b_in);
  end

endmodule

// File: rtl/full_sub_bist.sv
// Self-test engine for a 1-bit full subtractor. Walks all eight {a,b,b_in}
// combinations, holds each for SETTLE_CYCLES, then compares the returned
// differ/borrow against the golden model and accumulates results.
// Optional build macro: FULL_SUB_BIST_STOP_ON_FAIL_EN -- end the run at the
// first mismatching vector instead of applying all eight.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a run (honoured in IDLE or DONE only)
//   differ, borrow    response from the subtractor under test
//   a, b, b_in        registered stimulus to the subtractor
//   busy, done, pass  run status (registered)
//   err_count         mismatching vectors this run
//   fail_vec          index of the first mismatching vector
module full_sub_bist
  import full_sub_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             differ,
  input  logic             borrow,
  output logic             a,
  output logic             b,
  output logic             b_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

  state_e           state_q,      state_d;
  logic [VEC_W-1:0] idx_q,        idx_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [VEC_W-1:0] vec_q,        vec_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             pass_q,       pass_d;
  logic [ERR_W-1:0] err_count_q,  err_count_d;
  logic [VEC_W-1:0] fail_vec_q,   fail_vec_d;

  logic exp_d_c;
  logic exp_b_c;
  logic mismatch_c;
  logic stop_c;

  // Golden response for the vector currently being applied.
  full_sub_ref_model u_ref (
    .a     (idx_q[2]),
    .b     (idx_q[1]),
    .b_in  (idx_q[0]),
    .exp_d (exp_d_c),
    .exp_b (exp_b_c)
  );

  assign mismatch_c = (differ != exp_d_c) || (borrow != exp_b_c);

  // A run ends on the last vector, or on the first mismatch when stop-on-fail is built in.
`ifdef FULL_SUB_BIST_STOP_ON_FAIL_EN
  assign stop_c = (idx_q == LAST_VEC) || mismatch_c;
`else
  assign stop_c = (idx_q == LAST_VEC);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_vec_d   = fail_vec_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SETTLE;
          idx_d        = '0;
          settle_cnt_d = '0;
          vec_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = '0;
          fail_vec_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (mismatch_c) begin
          err_count_d = err_count_q + ERR_W'(1);
          if (err_count_q == '0) begin
            fail_vec_d = idx_q;
          end
        end
        if (stop_c) begin
          state_d = ST_DONE;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end else begin
          state_d      = ST_SETTLE;
          idx_d        = idx_q + VEC_W'(1);
          settle_cnt_d = '0;
          vec_d        = idx_q + VEC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign a         = vec_q[2];
  assign b         = vec_q[1];
  assign b_in      = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
